// File: rtl/encode_sched.sv
// encode_sched: round-robin arbiter sharing one encode FSM between NREQ requesters,
// driving its start pulse and repeat input and detecting sequence completion.
module encode_sched #(
  parameter int NREQ = 4,
  parameter int CNTW = 4,
  parameter int TMO  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*CNTW-1:0] rpt,
  input  logic                 enc_out,
  output logic                 mem,
  output logic                 a,
  output logic [NREQ-1:0]      gnt,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);
  localparam int IW = $clog2(NREQ);
  localparam int TW = $clog2(TMO + 1);
  typedef enum logic [2:0] {IDLE, START, RUN, WAIT, DONE} state_t;
  state_t          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d, idx_q, idx_d, win_idx, k;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [CNTW-1:0] rem_q, rem_d;
  logic [2:0]      ph_q, ph_d;
  logic [TW-1:0]   wcnt_q, wcnt_d;
  logic            seen_q, seen_d, err_q, err_d, win_ok;
  // first requester at or above ptr, wrapping
  always_comb begin
    win_ok = 1'b0;
    win_idx = '0;
    k = '0;
    for (int i = 0; i < NREQ; i++) begin
      k = IW'((int'(ptr_q) + i) % NREQ);
      if (!win_ok && req[k]) begin
        win_ok = 1'b1;
        win_idx = k;
      end
    end
  end
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    idx_d = idx_q;
    gnt_d = gnt_q;
    rem_d = rem_q;
    ph_d = ph_q;
    wcnt_d = wcnt_q;
    seen_d = seen_q;
    err_d = err_q;
    case (state_q)
      IDLE: if (win_ok) begin
        idx_d = win_idx;
        gnt_d = NREQ'(1) << win_idx;
        rem_d = rpt[int'(win_idx)*CNTW +: CNTW];
        state_d = START;
      end
      START: begin
        ph_d = '0;
        seen_d = 1'b0;
        state_d = RUN;
      end
      // phase 4 ends on the edge where the encoder samples a
      RUN: if (ph_q == 3'd4) begin
        if (rem_q != '0) begin
          rem_d = rem_q - CNTW'(1);
          ph_d = '0;
        end else begin
          wcnt_d = '0;
          state_d = WAIT;
        end
      end else ph_d = ph_q + 3'd1;
      WAIT: begin
        seen_d = seen_q | enc_out;
        wcnt_d = wcnt_q + TW'(1);
        if (seen_q && !enc_out) state_d = DONE;
        else if (wcnt_q == TW'(TMO - 1)) begin
          err_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        ptr_d = (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + IW'(1);
        gnt_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q <= '0;
      idx_q <= '0;
      gnt_q <= '0;
      rem_q <= '0;
      ph_q <= '0;
      wcnt_q <= '0;
      seen_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      idx_q <= idx_d;
      gnt_q <= gnt_d;
      rem_q <= rem_d;
      ph_q <= ph_d;
      wcnt_q <= wcnt_d;
      seen_q <= seen_d;
      err_q <= err_d;
    end
  end
  assign mem  = state_q == START;
  assign a    = (state_q == RUN) && (rem_q != '0);
  assign gnt  = gnt_q;
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign err  = err_q;
endmodule

// File: doc/encode_sched.md
# encode_sched

Round-robin scheduler that shares one `encode` state-machine instance between `NREQ` requesters. It grants the encoder to one requester at a time and issues the one-cycle `mem` start pulse. It drives the encoder's `a` repeat input from that requester's repeat count, and it detects sequence completion from the encoder's `out1` output. It sits between the requester blocks and the encoder and is the only agent that drives `mem` and `a`.

## Interface
- `NREQ`, default 4: number of requesters, 2..8.
- `CNTW`, default 4: width of each repeat count.
- `TMO`, default 16: maximum cycles in WAIT before the scheduler declares an error.

- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `req`  in  NREQ: request level per requester.
- `rpt`  in  NREQ*CNTW: repeat count, slice i is `rpt[i*CNTW +: CNTW]`; sampled only at grant.
- `enc_out`  in  1: encoder `out1`, which the encoder updates on the falling edge; sampled here on the rising edge.
- `mem`  out  1: encoder start pulse.
- `a`  out  1: encoder repeat request.
- `gnt`  out  NREQ: one-hot grant; all zero when idle.
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: one-cycle completion pulse, with `gnt` still valid.
- `err`  out  1: sticky timeout flag; cleared only by `rst`.

## Operation
- Reset value of every output is 0. Round-robin pointer `ptr` resets to 0; `rem` and the phase counter reset to 0.
- States: IDLE, START, RUN, WAIT, DONE.
- **IDLE**
  - If `req` is nonzero, select the first set bit at or above `ptr`, wrapping modulo NREQ.
  - Load `gnt` with the winner's one-hot code and `rem` with `rpt` of the winner.
  - Go to START.
  - If `req` is zero, stay in IDLE.
- **START**
  - `mem`=1 for exactly this cycle.
  - Go to RUN with phase=0 and `seen_hi`=0.
- **RUN**
  - Phase counts 0..4, mirroring encoder states 1..5.
  - `a` = (`rem`!=0), registered and stable for the whole pass.
  - At the edge ending phase 4 (the edge where the encoder samples `a`):
    - if `rem`!=0: `rem` <= `rem`-1 and phase <= 0, which starts another pass;
    - otherwise go to WAIT with the WAIT counter cleared.
- **WAIT**
  - `a`=0. Set `seen_hi` when `enc_out` is sampled 1.
  - When `seen_hi`=1 and `enc_out` is sampled 0, go to DONE.
  - If the WAIT counter reaches TMO, set `err`, then go to DONE.
- **DONE**
  - `done`=1 for one cycle.
  - `ptr` <= winner index + 1, modulo NREQ.
  - Next edge: `gnt` <= 0 and return to IDLE.
- A requester dropping `req` while granted has no effect; the encoder sequence cannot be aborted and always completes.
- A `rpt` change after grant is ignored.
- A new request arriving during an active sequence waits; arbitration happens only in IDLE.
- `mem` is never asserted outside START, so the encoder is never restarted mid-sequence.
- `rem` is CNTW wide, so the maximum number of repeats is 2^CNTW-1. No wrap-around can occur because `rem` only decrements when it is nonzero.

## Timing
- Label the edge at which IDLE sees a request as E0, and the cycle after edge En as Cn+1.
- Grant-to-`mem` latency: `gnt` and `busy` rise at E0; `mem` is high during C1.
- Repeat count 0:
  - RUN occupies C2..C6.
  - `enc_out` is sampled high at E7 and E8, then low at E9.
  - `done` is high during C10.
  - `gnt` and `busy` fall at E10.
- Each repeat adds exactly 5 cycles to the sequence.
- Back-to-back operation: with a request pending at E10, the next grant rises at E11. There is 1 idle cycle between sequences.
- Reset asserted mid-sequence:
  - All outputs go to 0 immediately (asynchronous); `err` is cleared.
  - The encoder must be reset by the same `rst`.

## Test plan
- `req`=0001, `rpt[0]`=0, with a behavioural encoder model:
  - `gnt`=0001 at E0, `mem` high only in C1, `a` held 0, `done` in C10;
  - `gnt`, `busy` and `done` are 0 from E10.
- `req`=0100, `rpt[2]`=3:
  - `a`=1 through three passes, then 0 on the fourth;
  - `done` in C25;
  - exactly one `mem` pulse.
- `req`=1111 held constantly, all `rpt`=0:
  - grants are issued in order 0001, 0010, 0100, 1000, 0001;
  - grants are 11 cycles apart;
  - exactly one `done` per grant.
- `req[1]` pulsed for one cycle while requester 0 is busy:
  - requester 1 is not granted after requester 0 finishes, because `req[1]` is low by then;
  - `ptr` advances to 1.
- Encoder model with `enc_out` stuck at 0:
  - WAIT times out after TMO=16 cycles;
  - `err`=1, then a one-cycle `done`, then `gnt`=0;
  - `err` stays 1 through subsequent grants.
- `rst` pulsed during RUN of a 2-repeat sequence:
  - `mem`, `a`, `gnt`, `busy`, `done` and `err` go to 0 asynchronously;
  - after release, the next request arbitrates from `ptr`=0.
